e_stage_mdu: RTL and testbench

//   Execute-stage multiply/divide unit. Consumes the MDU control fields issued by the

---
 rtl/e_stage_mdu.sv | 193 +++++++++++++++++++
 tb/tb_e_stage_mdu.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/e_stage_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : e_stage_mdu
//  Purpose  : Execute-stage multiply/divide unit. Runs multi-cycle
//             mult/multu/div/divu on latched operands, owns HI/LO and
//             reports busy to the hazard unit.
//  Revision : 1.0  initial release
// ============================================================================
module e_stage_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [3:0]  i_op,
  input  logic        i_out_sel,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  output logic        o_busy,
  output logic [31:0] o_result,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] c_OP_MULT  = 4'd1;
  localparam logic [3:0] c_OP_MULTU = 4'd2;
  localparam logic [3:0] c_OP_DIV   = 4'd3;
  localparam logic [3:0] c_OP_DIVU  = 4'd4;
  localparam logic [3:0] c_OP_MTHI  = 4'd5;
  localparam logic [3:0] c_OP_MTLO  = 4'd6;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [3:0]         r_op;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;

  logic               w_load;
  logic               w_done;
  logic               w_mt_hi;
  logic               w_mt_lo;
  logic               w_is_arith;
  logic               w_is_mul_op;

  // Arithmetic datapath on the latched operands, evaluated at completion
  logic [63:0]        w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_signed_div;
  logic [31:0]        w_a_mag;
  logic [31:0]        w_b_mag;
  logic [31:0]        w_b_safe;
  logic [31:0]        w_uq;
  logic [31:0]        w_ur;
  logic [31:0]        w_q;
  logic [31:0]        w_r;
  logic               w_div_zero;
  logic [31:0]        w_hi_new;
  logic [31:0]        w_lo_new;
  logic               w_wr_hilo;

  assign w_is_arith  = (i_op == c_OP_MULT) || (i_op == c_OP_MULTU) ||
                       (i_op == c_OP_DIV)  || (i_op == c_OP_DIVU);
  assign w_is_mul_op = (i_op == c_OP_MULT) || (i_op == c_OP_MULTU);

  // Sign-extending to 64 bits makes an unsigned multiply yield the signed product
  assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  // Signed divide is done on magnitudes; 0x80000000 has magnitude 0x80000000,
  // so the overflow case naturally yields quotient 0x80000000, remainder 0
  assign w_signed_div = (r_op == c_OP_DIV);
  assign w_a_mag      = (w_signed_div && r_a[31]) ? (32'd0 - r_a) : r_a;
  assign w_b_mag      = (w_signed_div && r_b[31]) ? (32'd0 - r_b) : r_b;
  assign w_div_zero   = (r_b == 32'd0);
  assign w_b_safe     = w_div_zero ? 32'd1 : w_b_mag;
  assign w_uq         = w_a_mag / w_b_safe;
  assign w_ur         = w_a_mag % w_b_safe;
  assign w_q          = (w_signed_div && (r_a[31] ^ r_b[31])) ? (32'd0 - w_uq) : w_uq;
  assign w_r          = (w_signed_div && r_a[31]) ? (32'd0 - w_ur) : w_ur;

  // Select the completion value for HI/LO; divide-by-zero leaves them untouched
  always_comb begin
    w_hi_new  = r_hi;
    w_lo_new  = r_lo;
    w_wr_hilo = 1'b0;
    case (r_op)
      c_OP_MULT: begin
        w_hi_new  = w_prod_s[63:32];
        w_lo_new  = w_prod_s[31:0];
        w_wr_hilo = 1'b1;
      end
      c_OP_MULTU: begin
        w_hi_new  = w_prod_u[63:32];
        w_lo_new  = w_prod_u[31:0];
        w_wr_hilo = 1'b1;
      end
      c_OP_DIV, c_OP_DIVU: begin
        w_hi_new  = w_r;
        w_lo_new  = w_q;
        w_wr_hilo = !w_div_zero;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control strobes; new starts and mt* only accepted when idle
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done      = 1'b0;
    w_mt_hi     = 1'b0;
    w_mt_lo     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && w_is_arith) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end else if (!i_start) begin
          w_mt_hi = (i_op == c_OP_MTHI);
          w_mt_lo = (i_op == c_OP_MTLO);
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latches and cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_a   <= 32'd0;
      r_b   <= 32'd0;
      r_op  <= 4'd0;
    end else if (w_load) begin
      r_a   <= i_rs_data;
      r_b   <= i_rt_data;
      r_op  <= i_op;
      r_cnt <= w_is_mul_op ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // HI/LO registers: written at completion or by mthi/mtlo
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_done) begin
      if (w_wr_hilo) begin
        r_hi <= w_hi_new;
        r_lo <= w_lo_new;
      end
    end else begin
      if (w_mt_hi) r_hi <= i_rs_data;
      if (w_mt_lo) r_lo <= i_rs_data;
    end
  end

  assign o_busy   = (r_state == S_RUN);
  assign o_hi     = r_hi;
  assign o_lo     = r_lo;
  assign o_result = i_out_sel ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: tb/tb_e_stage_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_e_stage_mdu
//  Purpose  : Directed self-checking bench for e_stage_mdu.
//  Revision : 1.0  initial release
// ============================================================================
module tb_e_stage_mdu;

  logic        clk;
  logic        reset;
  logic        i_start;
  logic [3:0]  i_op;
  logic        i_out_sel;
  logic [31:0] i_rs_data;
  logic [31:0] i_rt_data;
  logic        o_busy;
  logic [31:0] o_result;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int checks;
  int errors;

  e_stage_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_start   (i_start),
    .i_op      (i_op),
    .i_out_sel (i_out_sel),
    .i_rs_data (i_rs_data),
    .i_rt_data (i_rt_data),
    .o_busy    (o_busy),
    .o_result  (o_result),
    .o_hi      (o_hi),
    .o_lo      (o_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit later
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue an arithmetic op and count edges until busy drops (bounded)
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int n);
    i_start = 1'b1; i_op = op; i_rs_data = a; i_rt_data = b;
    tick();
    i_start = 1'b0; i_op = 4'd0;
    n = 0;
    while (o_busy && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_out_sel = 1'b0;
    #1;
    checks++; if (o_hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want %h", o_hi, 32'd0); end
    checks++; if (o_lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want %h", o_lo, 32'd0); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    checks++; if (o_result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want %h", o_result, 32'd0); end
  endtask

  task automatic test_mult;
    int n;
    run_op(4'd1, 32'hFFFFFFFE, 32'd3, n);
    checks++; if (n != 5) begin errors++; $display("FAIL mult_busy_cycles got %0d want 5", n); end
    checks++; if (o_hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", o_hi); end
    checks++; if (o_lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", o_lo); end
    i_out_sel = 1'b1; #1;
    checks++; if (o_result !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_result_hi got %h want ffffffff", o_result); end
    i_out_sel = 1'b0; #1;
    checks++; if (o_result !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_result_lo got %h want fffffffa", o_result); end
  endtask

  task automatic test_multu;
    int n;
    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
    checks++; if (n != 5) begin errors++; $display("FAIL multu_busy_cycles got %0d want 5", n); end
    checks++; if (o_hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", o_hi); end
    checks++; if (o_lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h want 00000001", o_lo); end
  endtask

  task automatic test_div;
    int n;
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, n);
    checks++; if (n != 10) begin errors++; $display("FAIL div_busy_cycles got %0d want 10", n); end
    checks++; if (o_lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", o_lo); end
    checks++; if (o_hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", o_hi); end
    // divide by zero keeps the previous HI/LO
    run_op(4'd4, 32'd7, 32'd0, n);
    checks++; if (n != 10) begin errors++; $display("FAIL divu0_busy_cycles got %0d want 10", n); end
    checks++; if (o_lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL divu0_lo got %h want fffffffd", o_lo); end
    checks++; if (o_hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0_hi got %h want ffffffff", o_hi); end
    // unsigned divide, large dividend
    run_op(4'd4, 32'hFFFFFFF9, 32'd2, n);
    checks++; if (o_lo !== 32'h7FFFFFFC) begin errors++; $display("FAIL divu_lo got %h want 7ffffffc", o_lo); end
    checks++; if (o_hi !== 32'd1) begin errors++; $display("FAIL divu_hi got %h want 00000001", o_hi); end
    // signed overflow case
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, n);
    checks++; if (o_lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", o_lo); end
    checks++; if (o_hi !== 32'd0) begin errors++; $display("FAIL div_ovf_hi got %h want 00000000", o_hi); end
    // positive dividend, negative divisor
    run_op(4'd3, 32'd7, 32'hFFFFFFFE, n);
    checks++; if (o_lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negb_lo got %h want fffffffd", o_lo); end
    checks++; if (o_hi !== 32'd1) begin errors++; $display("FAIL div_negb_hi got %h want 00000001", o_hi); end
  endtask

  task automatic test_mt;
    logic [31:0] lo_before;
    lo_before = o_lo;
    i_start = 1'b0; i_op = 4'd5; i_rs_data = 32'h12345678;
    tick();
    checks++; if (o_hi !== 32'h12345678) begin errors++; $display("FAIL mthi_hi got %h want 12345678", o_hi); end
    checks++; if (o_lo !== lo_before) begin errors++; $display("FAIL mthi_lo_kept got %h want %h", o_lo, lo_before); end
    i_op = 4'd6; i_rs_data = 32'h9ABCDEF0;
    tick();
    i_op = 4'd0;
    checks++; if (o_lo !== 32'h9ABCDEF0) begin errors++; $display("FAIL mtlo_lo got %h want 9abcdef0", o_lo); end
    i_out_sel = 1'b1; #1;
    checks++; if (o_result !== 32'h12345678) begin errors++; $display("FAIL mt_result_hi got %h want 12345678", o_result); end
    i_out_sel = 1'b0; #1;
    checks++; if (o_result !== 32'h9ABCDEF0) begin errors++; $display("FAIL mt_result_lo got %h want 9abcdef0", o_result); end
    // start with a non-arithmetic op is ignored
    i_start = 1'b1; i_op = 4'd7; i_rs_data = 32'h0BAD0BAD;
    tick();
    i_start = 1'b0; i_op = 4'd0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL bad_start_busy got %b want 0", o_busy); end
    checks++; if (o_hi !== 32'h12345678) begin errors++; $display("FAIL bad_start_hi got %h want 12345678", o_hi); end
  endtask

  task automatic test_robust;
    int n;
    // reset during a divide
    i_start = 1'b1; i_op = 4'd3; i_rs_data = 32'd100; i_rt_data = 32'd7;
    tick();
    i_start = 1'b0; i_op = 4'd0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", o_busy); end
    checks++; if (o_hi !== 32'd0) begin errors++; $display("FAIL rst_mid_hi got %h want 0", o_hi); end
    checks++; if (o_lo !== 32'd0) begin errors++; $display("FAIL rst_mid_lo got %h want 0", o_lo); end
    // nothing completes later from the dropped op
    for (int k = 0; k < 12; k++) tick();
    checks++; if (o_lo !== 32'd0) begin errors++; $display("FAIL rst_mid_late_lo got %h want 0", o_lo); end
    // start and mthi while busy are ignored
    i_start = 1'b1; i_op = 4'd1; i_rs_data = 32'd3; i_rt_data = 32'd4;
    tick();
    n = 0;
    i_start = 1'b1; i_op = 4'd3; i_rs_data = 32'd100; i_rt_data = 32'd7;
    n++; tick();
    i_start = 1'b0; i_op = 4'd5; i_rs_data = 32'hDEADBEEF;
    n++; tick();
    i_op = 4'd0;
    checks++; if (o_hi !== 32'd0) begin errors++; $display("FAIL mthi_busy_hi got %h want 0", o_hi); end
    while (o_busy && n < 50) begin
      n++;
      tick();
    end
    checks++; if (n != 5) begin errors++; $display("FAIL restart_busy_cycles got %0d want 5", n); end
    checks++; if (o_lo !== 32'd12) begin errors++; $display("FAIL restart_lo got %h want 0000000c", o_lo); end
    checks++; if (o_hi !== 32'd0) begin errors++; $display("FAIL restart_hi got %h want 0", o_hi); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    i_start   = 1'b0;
    i_op      = 4'd0;
    i_out_sel = 1'b0;
    i_rs_data = 32'd0;
    i_rt_data = 32'd0;
    tick();
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_mt();
    test_robust();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
